// File: rtl/interval_timer_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// interval_timer_scheduler_pkg
//   Shared definitions for the interval timer scheduler:
//     state_t : FSM state encoding (ST_IDLE, ST_RUN)
//     id_w()  : width of a requester index, max(1, clog2(n_req))
// ----------------------------------------------------------------------------
package interval_timer_scheduler_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // A single requester index still needs one bit, hence the floor of 1.
   function automatic int id_w(input int n_req);
      return (n_req > 2) ? $clog2(n_req) : 1;
   endfunction

endpackage

// File: rtl/interval_timer_scheduler_if.sv
// ----------------------------------------------------------------------------
// interval_timer_scheduler_if
//   Bundles the requester-side request/length/abort signals and the
//   scheduler's status outputs.
//     req     : per-requester request level           (master -> slave)
//     len     : per-requester interval, CNT_W each     (master -> slave)
//     abort   : cancel running interval                (master -> slave)
//     grant   : one-hot accept pulse                   (slave -> master)
//     busy    : interval in progress                   (slave -> master)
//     owner   : current / last owner index             (slave -> master)
//     q       : live counter value                     (slave -> master)
//     done    : normal-completion pulse                (slave -> master)
//     done_id : owner index qualified by done          (slave -> master)
// ----------------------------------------------------------------------------
interface interval_timer_scheduler_if
   import interval_timer_scheduler_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int CNT_W = 4
);
   localparam int ID_W = id_w(N_REQ);

   logic [N_REQ-1:0]       req;
   logic [N_REQ*CNT_W-1:0] len;
   logic                   abort;
   logic [N_REQ-1:0]       grant;
   logic                   busy;
   logic [ID_W-1:0]        owner;
   logic [CNT_W-1:0]       q;
   logic                   done;
   logic [ID_W-1:0]        done_id;

   modport master (
      output req, len, abort,
      input  grant, busy, owner, q, done, done_id
   );

   modport slave (
      input  req, len, abort,
      output grant, busy, owner, q, done, done_id
   );

endinterface

// File: rtl/interval_timer_scheduler_sync_up_counter.sv
// ----------------------------------------------------------------------------
// sync_up_counter
//   Free-running CNT_W-bit up-counter with synchronous clear.
//     clk   : clock
//     reset : asynchronous active-high reset
//     clr   : synchronous clear (wins over en)
//     en    : count enable
//     q     : counter value
// ----------------------------------------------------------------------------
module sync_up_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] q
);

   logic [CNT_W-1:0] r_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= r_q + CNT_W'(1);
      end
   end

   assign q = r_q;

endmodule

// File: rtl/interval_timer_scheduler.sv
// ----------------------------------------------------------------------------
// interval_timer_scheduler
//   Shares one up-counter among N_REQ requesters. A round-robin arbiter picks
//   one requester, latches its interval length and counts it out; a one-cycle
//   done pulse tagged with the owner index marks normal completion.
//     clk   : clock, rising edge
//     reset : asynchronous active-high reset
//     bus   : slave side of interval_timer_scheduler_if
//             (req/len/abort in; grant/busy/owner/q/done/done_id out)
// ----------------------------------------------------------------------------
module interval_timer_scheduler
   import interval_timer_scheduler_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int CNT_W = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   interval_timer_scheduler_if.slave bus
);

   localparam int ID_W = id_w(N_REQ);

   state_t           r_state,   w_state_next;
   logic [N_REQ-1:0] r_grant,   w_grant_next;
   logic             r_busy,    w_busy_next;
   logic [ID_W-1:0]  r_owner,   w_owner_next;
   logic             r_done,    w_done_next;
   logic [ID_W-1:0]  r_done_id, w_done_id_next;
   logic [ID_W-1:0]  r_rr_ptr,  w_rr_ptr_next;
   logic [CNT_W-1:0] r_len_q,   w_len_q_next;

   logic [CNT_W-1:0]   w_q;
   logic               w_clr;
   logic               w_en;
   logic               w_final;
   logic [CNT_W-1:0]   w_len_arr [N_REQ];
   logic [2*N_REQ-1:0] w_req_dbl;
   logic [N_REQ-1:0]   w_req_rot;
   logic [ID_W-1:0]    w_enc;
   logic [ID_W:0]      w_sum;
   logic [ID_W-1:0]    w_winner;

   // Per-requester length slices.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len
         assign w_len_arr[gi] = bus.len[gi*CNT_W +: CNT_W];
      end
   endgenerate

   // Arbiter: rotate so rr_ptr lands on bit 0, pick the lowest set bit,
   // then add rr_ptr back (mod N_REQ) to recover the real index.
   assign w_req_dbl = {bus.req, bus.req} >> r_rr_ptr;
   assign w_req_rot = w_req_dbl[N_REQ-1:0];

   always_comb begin
      w_enc = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_req_rot[k]) begin
            w_enc = ID_W'(k);
         end
      end
   end

   assign w_sum    = {1'b0, w_enc} + {1'b0, r_rr_ptr};
   assign w_winner = (w_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(w_sum - (ID_W+1)'(N_REQ))
                                                 : ID_W'(w_sum);

   // len_q == 0 wraps to all-ones here, which yields a full 2**CNT_W interval.
   assign w_final = (w_q == (r_len_q - CNT_W'(1)));

   always_comb begin
      w_state_next   = r_state;
      w_grant_next   = '0;
      w_busy_next    = r_busy;
      w_owner_next   = r_owner;
      w_done_next    = 1'b0;
      w_done_id_next = r_done_id;
      w_rr_ptr_next  = r_rr_ptr;
      w_len_q_next   = r_len_q;
      w_clr          = 1'b0;
      w_en           = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // abort is ignored here so it cannot block a grant.
            if (|bus.req) begin
               w_state_next  = ST_RUN;
               w_grant_next  = N_REQ'(1) << w_winner;
               w_busy_next   = 1'b1;
               w_owner_next  = w_winner;
               w_len_q_next  = w_len_arr[w_winner];
               w_rr_ptr_next = (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + ID_W'(1);
               w_clr         = 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               // Abort beats completion: no done on the final-count edge.
               w_state_next = ST_IDLE;
               w_busy_next  = 1'b0;
               w_clr        = 1'b1;
            end else if (w_final) begin
               w_state_next   = ST_IDLE;
               w_busy_next    = 1'b0;
               w_done_next    = 1'b1;
               w_done_id_next = r_owner;
               w_clr          = 1'b1;
            end else begin
               w_en = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_busy    <= 1'b0;
         r_owner   <= '0;
         r_done    <= 1'b0;
         r_done_id <= '0;
         r_rr_ptr  <= '0;
         r_len_q   <= '0;
      end else begin
         r_state   <= w_state_next;
         r_grant   <= w_grant_next;
         r_busy    <= w_busy_next;
         r_owner   <= w_owner_next;
         r_done    <= w_done_next;
         r_done_id <= w_done_id_next;
         r_rr_ptr  <= w_rr_ptr_next;
         r_len_q   <= w_len_q_next;
      end
   end

   sync_up_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (w_clr),
      .en    (w_en),
      .q     (w_q)
   );

   assign bus.grant   = r_grant;
   assign bus.busy    = r_busy;
   assign bus.owner   = r_owner;
   assign bus.q       = w_q;
   assign bus.done    = r_done;
   assign bus.done_id = r_done_id;

endmodule

// File: tb/tb_interval_timer_scheduler.sv
// ----------------------------------------------------------------------------
// tb_interval_timer_scheduler
//   Directed scenarios plus randomized traffic against a behavioural model
//   that tracks each interval as (owner, elapsed cycles, length L).
// ----------------------------------------------------------------------------
module tb_interval_timer_scheduler;

   localparam int N = 3;
   localparam int W = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   interval_timer_scheduler_if #(.N_REQ(N), .CNT_W(W)) bus ();

   interval_timer_scheduler #(
      .N_REQ (N),
      .CNT_W (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit busy;
      int owner;
      int elapsed;   // cycles since the grant cycle
      int L;         // interval length in cycles (1..2**W)
      int ptr;       // next requester to look at first
      bit done;
      int done_id;
   } model_t;

   localparam model_t RESET_M = '{busy: 0, owner: 0, elapsed: 0, L: 0, ptr: 0, done: 0, done_id: 0};

   model_t m = RESET_M;

   function automatic model_t step(input model_t cur, input logic [N-1:0] rq,
                                   input logic [N*W-1:0] ln, input logic ab);
      model_t nx;
      bit     found;
      int     idx;
      int     l;
      nx      = cur;
      nx.done = 0;
      found   = 0;
      if (cur.busy) begin
         if (ab) begin
            nx.busy    = 0;
            nx.elapsed = 0;
         end else if (cur.elapsed + 1 == cur.L) begin
            nx.busy    = 0;
            nx.elapsed = 0;
            nx.done    = 1;
            nx.done_id = cur.owner;
         end else begin
            nx.elapsed = cur.elapsed + 1;
         end
      end else if (rq != 0) begin
         for (int k = 0; k < N; k++) begin
            idx = (cur.ptr + k) % N;
            if (!found && rq[idx]) begin
               found      = 1;
               nx.busy    = 1;
               nx.owner   = idx;
               nx.elapsed = 0;
               l          = int'(ln[idx*W +: W]);
               nx.L       = (l == 0) ? (1 << W) : l;
               nx.ptr     = (idx + 1) % N;
            end
         end
      end
      return nx;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m <= RESET_M;
      else       m <= step(m, bus.req, bus.len, bus.abort);
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (!reset) begin
         chk("grant",   32'(bus.grant),   (m.busy && m.elapsed == 0) ? (32'd1 << m.owner) : 32'd0);
         chk("busy",    32'(bus.busy),    32'(m.busy));
         chk("owner",   32'(bus.owner),   32'(m.owner));
         chk("q",       32'(bus.q),       32'(m.elapsed % (1 << W)));
         chk("done",    32'(bus.done),    32'(m.done));
         chk("done_id", 32'(bus.done_id), 32'(m.done_id));
         chk("grant_done_excl", 32'((bus.grant != 0) && bus.done), 32'd0);
      end
   end

   // ---------------- helpers ----------------
   task automatic set_len(input int l0, input int l1, input int l2);
      bus.len = {W'(l2), W'(l1), W'(l0)};
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_grant(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.grant != 0) seen = 1;
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   task automatic count_done(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (bus.done) cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1);
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      int gc[$];
      int go[$];
      int cnt;
      int g1cnt;

      bus.req   = '0;
      bus.len   = '0;
      bus.abort = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset values
      chk("rst_grant",   32'(bus.grant),   0);
      chk("rst_busy",    32'(bus.busy),    0);
      chk("rst_owner",   32'(bus.owner),   0);
      chk("rst_q",       32'(bus.q),       0);
      chk("rst_done",    32'(bus.done),    0);
      chk("rst_done_id", 32'(bus.done_id), 0);

      // 1. single request, len 3
      bus.req = 3'b001;
      set_len(3, 0, 0);
      wait_grant("t1_grant_seen");
      chk("t1_grant", 32'(bus.grant), 1);
      chk("t1_q0",    32'(bus.q),     0);
      bus.req = '0;
      @(negedge clk); chk("t1_q1", 32'(bus.q), 1);
      @(negedge clk); chk("t1_q2", 32'(bus.q), 2);
      @(negedge clk);
      chk("t1_done",    32'(bus.done),    1);
      chk("t1_done_id", 32'(bus.done_id), 0);
      chk("t1_busy",    32'(bus.busy),    0);
      chk("t1_q_end",   32'(bus.q),       0);
      @(negedge clk); chk("t1_done_off", 32'(bus.done), 0);

      // 2. two requesters held, len 2: alternate, 3 cycles apart
      do_reset();
      bus.req = 3'b011;
      set_len(2, 2, 2);
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (bus.grant != 0) begin
            gc.push_back(c);
            go.push_back(int'(bus.grant));
         end
      end
      chk("t2_ngrants", 32'(gc.size() >= 4), 1);
      if (gc.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("t2_order", 32'(go[i]), (i % 2 == 0) ? 1 : 2);
            if (i > 0) chk("t2_spacing", 32'(gc[i] - gc[i-1]), 3);
         end
      end
      bus.req = '0;
      repeat (4) @(negedge clk);

      // 3. len 0 -> full 16-cycle interval
      bus.req = 3'b001;
      set_len(0, 5, 5);
      wait_grant("t3_grant_seen");
      bus.req = '0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 15) chk("t3_q15", 32'(bus.q), 15);
         if (k < 16)  chk("t3_no_early_done", 32'(bus.done), 0);
         if (k == 16) begin
            chk("t3_done", 32'(bus.done), 1);
            chk("t3_q_wrap", 32'(bus.q), 0);
         end
      end

      // 4a. abort mid-interval at q=2
      bus.req = 3'b001;
      set_len(5, 0, 0);
      wait_grant("t4a_grant_seen");
      bus.req = '0;
      repeat (2) @(negedge clk);
      chk("t4a_q2", 32'(bus.q), 2);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("t4a_busy", 32'(bus.busy), 0);
      chk("t4a_q",    32'(bus.q),    0);
      count_done(8, cnt);
      chk("t4a_no_done", 32'(cnt), 0);

      // 4b. abort on the final-count edge
      bus.req = 3'b001;
      set_len(3, 0, 0);
      wait_grant("t4b_grant_seen");
      bus.req = '0;
      repeat (2) @(negedge clk);
      chk("t4b_q2", 32'(bus.q), 2);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("t4b_done", 32'(bus.done), 0);
      chk("t4b_busy", 32'(bus.busy), 0);
      count_done(5, cnt);
      chk("t4b_no_done", 32'(cnt), 0);

      // 5. asynchronous reset mid-interval at q=5
      bus.req = 3'b010;
      set_len(0, 9, 0);
      wait_grant("t5_grant_seen");
      bus.req = '0;
      repeat (5) @(negedge clk);
      chk("t5_q5",    32'(bus.q),     5);
      chk("t5_owner", 32'(bus.owner), 1);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_grant",   32'(bus.grant),   0);
      chk("t5_rst_busy",    32'(bus.busy),    0);
      chk("t5_rst_owner",   32'(bus.owner),   0);
      chk("t5_rst_q",       32'(bus.q),       0);
      chk("t5_rst_done",    32'(bus.done),    0);
      chk("t5_rst_done_id", 32'(bus.done_id), 0);
      @(negedge clk);
      reset   = 1'b0;
      bus.req = 3'b011;
      set_len(2, 2, 2);
      wait_grant("t5_grant2_seen");
      chk("t5_first_to_req0", 32'(bus.grant), 1);
      bus.req = '0;
      repeat (4) @(negedge clk);

      // 6. one-cycle req1 pulse while busy is forgotten; abort in IDLE is inert
      bus.req = 3'b001;
      set_len(4, 4, 4);
      wait_grant("t6_grant_seen");
      bus.req = '0;
      @(negedge clk);
      bus.req = 3'b010;
      @(negedge clk);
      bus.req = '0;
      g1cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.grant[1]) g1cnt++;
      end
      chk("t6_no_grant_req1", 32'(g1cnt), 0);
      bus.abort = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t6_idle_abort_busy", 32'(bus.busy), 0);
         chk("t6_idle_abort_q",    32'(bus.q),    0);
      end
      bus.req = 3'b100;
      wait_grant("t6_abort_grant_seen");
      chk("t6_grant_despite_abort", 32'(bus.grant), 4);
      bus.abort = 1'b0;
      bus.req   = '0;
      repeat (6) @(negedge clk);

      // Randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         bus.req   = N'($urandom_range(0, (1 << N) - 1));
         bus.len   = (N*W)'($urandom);
         bus.abort = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      bus.req   = '0;
      bus.abort = 1'b0;
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
